// File: rtl/gb_bus_responder.sv
// Memory-side bus responder: HRAM, IF/IE interrupt registers and external forwarding with timeout.
// Optional macro ECHO_RAM_EN forwards 0xE000-0xFDFF externally as 0xC000-0xDDFF.
module gb_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] HRAM_BASE      = 16'hFF80
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [15:0] i_Address,
    input  logic        i_Address_Out,
    input  logic [7:0]  i_Bus,
    input  logic        i_Bus_Out,
    input  logic        i_Bus_In,
    input  logic        i_Handle_Interrupt,
    input  logic [4:0]  i_Irq_Lines,
    output logic [7:0]  o_Bus,
    output logic        o_Busy,
    output logic [4:0]  o_Interrupts,
    output logic        o_Bus_Error,
    output logic        o_Ext_Req,
    output logic        o_Ext_We,
    output logic [15:0] o_Ext_Address,
    output logic [7:0]  o_Ext_Data,
    input  logic [7:0]  i_Ext_Data,
    input  logic        i_Ext_Ack
);

    typedef enum logic {IDLE, EXT_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] addr_q, eff_addr;
    logic [7:0]  bus_q, bus_d;
    logic        busy_q, busy_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_data_q, ext_data_d;
    logic        bus_error_d, bus_error_q;
    logic [4:0]  if_q, if_d, ie_q, ie_d;
    logic [4:0]  irq_prev_q, irq_prev_d;
    logic        handle_prev_q, handle_prev_d;

    logic [7:0]  hram [0:126];
    logic [6:0]  hram_idx;
    logic        hram_we;

    logic        wr_stb, rd_stb;
    logic        is_hram, is_if, is_ie, is_hole, is_echo, int_hit;
    logic [7:0]  int_rdata;
    logic [15:0] fwd_addr;
    logic [4:0]  pending, irq_edges, clr_mask;

    // A strobe in the same cycle as a new address decodes the new address.
    assign eff_addr = (i_Enable && i_Address_Out) ? i_Address : addr_q;
    assign wr_stb   = i_Bus_Out;
    assign rd_stb   = i_Bus_In && !i_Bus_Out;

    assign is_if    = (eff_addr == 16'hFF0F);
    assign is_ie    = (eff_addr == 16'hFFFF);
    assign is_hram  = (eff_addr >= HRAM_BASE) && !is_ie;
    assign is_hole  = (eff_addr >= 16'hFEA0) && (eff_addr <= 16'hFEFF);
    assign is_echo  = (eff_addr >= 16'hE000) && (eff_addr <= 16'hFDFF);
    assign hram_idx = eff_addr[6:0] - HRAM_BASE[6:0];

`ifdef ECHO_RAM_EN
    assign int_hit  = is_hram || is_if || is_ie || is_hole;
    assign fwd_addr = is_echo ? (eff_addr - 16'h2000) : eff_addr;
`else
    assign int_hit  = is_hram || is_if || is_ie || is_hole || is_echo;
    assign fwd_addr = eff_addr;
`endif

    always_comb begin
        int_rdata = 8'hFF;
        if (is_if)        int_rdata = {3'b111, if_q};
        else if (is_ie)   int_rdata = {3'b000, ie_q};
        else if (is_hram) int_rdata = hram[hram_idx];
    end

    assign pending   = if_q & ie_q;
    assign irq_edges = i_Irq_Lines & ~irq_prev_q;
    // Isolate the lowest set pending bit (highest priority).
    assign clr_mask  = (i_Handle_Interrupt && !handle_prev_q) ? (pending & (~pending + 5'd1)) : 5'd0;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        bus_d         = bus_q;
        busy_d        = busy_q;
        req_d         = req_q;
        we_d          = we_q;
        ext_addr_d    = ext_addr_q;
        ext_data_d    = ext_data_q;
        bus_error_d   = 1'b0;
        if_d          = if_q;
        ie_d          = ie_q;
        irq_prev_d    = irq_prev_q;
        handle_prev_d = handle_prev_q;
        hram_we       = 1'b0;

        if (i_Enable) begin
            irq_prev_d    = i_Irq_Lines;
            handle_prev_d = i_Handle_Interrupt;
            if_d          = if_q & ~clr_mask;

            case (state_q)
                IDLE: begin
                    if (wr_stb || rd_stb) begin
                        if (int_hit) begin
                            if (wr_stb) begin
                                hram_we = is_hram;
                                if (is_if) if_d = i_Bus[4:0];
                                if (is_ie) ie_d = i_Bus[4:0];
                            end else begin
                                bus_d = int_rdata;
                            end
                        end else begin
                            state_d    = EXT_WAIT;
                            wait_d     = 8'd0;
                            req_d      = 1'b1;
                            busy_d     = 1'b1;
                            we_d       = wr_stb;
                            ext_addr_d = fwd_addr;
                            ext_data_d = i_Bus;
                        end
                    end
                end
                EXT_WAIT: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (i_Ext_Ack || wait_q == WAIT_LAST) begin
                        if (!we_q) bus_d = i_Ext_Ack ? i_Ext_Data : 8'hFF;
                        bus_error_d = !i_Ext_Ack;
                        state_d     = IDLE;
                        req_d       = 1'b0;
                        busy_d      = 1'b0;
                        we_d        = 1'b0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Source edges override both clears and CPU writes to IF.
            if_d = if_d | irq_edges;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            addr_q        <= 16'd0;
            bus_q         <= 8'hFF;
            busy_q        <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            ext_addr_q    <= 16'd0;
            ext_data_q    <= 8'd0;
            bus_error_q   <= 1'b0;
            if_q          <= 5'd0;
            ie_q          <= 5'd0;
            irq_prev_q    <= 5'd0;
            handle_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            addr_q        <= eff_addr;
            bus_q         <= bus_d;
            busy_q        <= busy_d;
            req_q         <= req_d;
            we_q          <= we_d;
            ext_addr_q    <= ext_addr_d;
            ext_data_q    <= ext_data_d;
            bus_error_q   <= bus_error_d;
            if_q          <= if_d;
            ie_q          <= ie_d;
            irq_prev_q    <= irq_prev_d;
            handle_prev_q <= handle_prev_d;
        end
    end

    // NOTE: HRAM has no reset so it maps onto plain RAM; software initialises it.
    always_ff @(posedge i_Clk) begin
        if (hram_we && !i_Reset) hram[hram_idx] <= i_Bus;
    end

    assign o_Bus         = bus_q;
    assign o_Busy        = busy_q;
    assign o_Interrupts  = pending;
    assign o_Bus_Error   = bus_error_q;
    assign o_Ext_Req     = req_q;
    assign o_Ext_We      = we_q;
    assign o_Ext_Address = ext_addr_q;
    assign o_Ext_Data    = ext_data_q;

endmodule

// File: tb/tb_gb_bus_responder.sv
// Directed self-checking bench for gb_bus_responder, built with TIMEOUT_CYCLES=4.
module tb_gb_bus_responder;

    logic        i_Clk = 1'b0;
    logic        i_Reset, i_Enable;
    logic [15:0] i_Address;
    logic        i_Address_Out;
    logic [7:0]  i_Bus;
    logic        i_Bus_Out, i_Bus_In, i_Handle_Interrupt;
    logic [4:0]  i_Irq_Lines;
    logic [7:0]  o_Bus;
    logic        o_Busy;
    logic [4:0]  o_Interrupts;
    logic        o_Bus_Error, o_Ext_Req, o_Ext_We;
    logic [15:0] o_Ext_Address;
    logic [7:0]  o_Ext_Data;
    logic [7:0]  i_Ext_Data;
    logic        i_Ext_Ack;

    int checks = 0;
    int failures = 0;

    gb_bus_responder #(.TIMEOUT_CYCLES(4), .HRAM_BASE(16'hFF80)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
        .i_Address(i_Address), .i_Address_Out(i_Address_Out),
        .i_Bus(i_Bus), .i_Bus_Out(i_Bus_Out), .i_Bus_In(i_Bus_In),
        .i_Handle_Interrupt(i_Handle_Interrupt), .i_Irq_Lines(i_Irq_Lines),
        .o_Bus(o_Bus), .o_Busy(o_Busy), .o_Interrupts(o_Interrupts),
        .o_Bus_Error(o_Bus_Error), .o_Ext_Req(o_Ext_Req), .o_Ext_We(o_Ext_We),
        .o_Ext_Address(o_Ext_Address), .o_Ext_Data(o_Ext_Data),
        .i_Ext_Data(i_Ext_Data), .i_Ext_Ack(i_Ext_Ack)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic quiet();
        i_Address_Out = 1'b0; i_Bus_Out = 1'b0; i_Bus_In = 1'b0;
        i_Ext_Ack = 1'b0; i_Handle_Interrupt = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        i_Address = a; i_Address_Out = 1'b1; i_Bus = d; i_Bus_Out = 1'b1;
        tick();
        quiet();
    endtask

    task automatic cpu_read(input logic [15:0] a);
        i_Address = a; i_Address_Out = 1'b1; i_Bus_In = 1'b1;
        tick();
        quiet();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1; i_Enable = 1'b1; i_Address = 16'h0; i_Bus = 8'h0;
        i_Irq_Lines = 5'd0; i_Ext_Data = 8'h0;
        quiet();
        tick(); tick();
        check("rst_bus", o_Bus, 8'hFF);
        check("rst_busy", o_Busy, 1'b0);
        check("rst_req", o_Ext_Req, 1'b0);
        check("rst_irq", o_Interrupts, 5'd0);
        check("rst_err", o_Bus_Error, 1'b0);
        check("rst_eaddr", o_Ext_Address, 16'h0);
        i_Reset = 1'b0;
        tick();

        // HRAM write then read
        cpu_write(16'hFF85, 8'h5A);
        check("hram_wr_busy", o_Busy, 1'b0);
        check("hram_wr_req", o_Ext_Req, 1'b0);
        check("hram_wr_bus_hold", o_Bus, 8'hFF);
        i_Bus_In = 1'b1;  // uses latched address
        tick();
        quiet();
        check("hram_rd", o_Bus, 8'h5A);
        check("hram_rd_busy", o_Busy, 1'b0);
        check("hram_rd_req", o_Ext_Req, 1'b0);

        // External read acked on the third wait cycle
        cpu_read(16'hC123);
        check("ext_rd_req", o_Ext_Req, 1'b1);
        check("ext_rd_busy", o_Busy, 1'b1);
        check("ext_rd_we", o_Ext_We, 1'b0);
        check("ext_rd_addr", o_Ext_Address, 16'hC123);
        tick();
        check("ext_rd_req_w1", o_Ext_Req, 1'b1);
        i_Bus_In = 1'b1; i_Address_Out = 1'b1; i_Address = 16'hFF85;  // ignored while busy
        tick();
        quiet();
        check("ext_rd_req_w2", o_Ext_Req, 1'b1);
        check("ext_rd_addr_hold", o_Ext_Address, 16'hC123);
        i_Ext_Ack = 1'b1; i_Ext_Data = 8'h3C;
        tick();
        quiet();
        check("ext_rd_data", o_Bus, 8'h3C);
        check("ext_rd_req_done", o_Ext_Req, 1'b0);
        check("ext_rd_busy_done", o_Busy, 1'b0);

        // Timeout after 4 enabled wait cycles
        cpu_read(16'h8000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_no_err", o_Bus_Error, 1'b0);
            check("to_req_held", o_Ext_Req, 1'b1);
        end
        i_Enable = 1'b0;  // a disabled cycle does not count
        tick();
        check("to_disabled", o_Ext_Req, 1'b1);
        i_Enable = 1'b1;
        tick();
        check("to_err", o_Bus_Error, 1'b1);
        check("to_bus", o_Bus, 8'hFF);
        check("to_req", o_Ext_Req, 1'b0);
        check("to_busy", o_Busy, 1'b0);
        tick();
        check("to_err_pulse", o_Bus_Error, 1'b0);
        cpu_read(16'hFF85);
        check("to_hram_rd", o_Bus, 8'h5A);

        // Ack on the timeout cycle is a success
        cpu_read(16'h9000);
        tick(); tick(); tick();
        i_Ext_Ack = 1'b1; i_Ext_Data = 8'h77;
        tick();
        quiet();
        check("to_ack_err", o_Bus_Error, 1'b0);
        check("to_ack_bus", o_Bus, 8'h77);

        // External write
        cpu_write(16'hA000, 8'h42);
        check("ext_wr_we", o_Ext_We, 1'b1);
        check("ext_wr_data", o_Ext_Data, 8'h42);
        check("ext_wr_addr", o_Ext_Address, 16'hA000);
        i_Ext_Ack = 1'b1; i_Ext_Data = 8'hEE;
        tick();
        quiet();
        check("ext_wr_req_done", o_Ext_Req, 1'b0);
        check("ext_wr_bus_hold", o_Bus, 8'h77);

        // Simultaneous strobes: write wins
        i_Address = 16'hFF90; i_Address_Out = 1'b1; i_Bus = 8'h11;
        i_Bus_Out = 1'b1; i_Bus_In = 1'b1;
        tick();
        quiet();
        check("both_bus_hold", o_Bus, 8'h77);
        cpu_read(16'hFF90);
        check("both_rd", o_Bus, 8'h11);

        // Interrupts
        cpu_write(16'hFFFF, 8'h05);
        i_Irq_Lines = 5'b00101;
        tick();
        i_Irq_Lines = 5'b00000;
        check("irq_set", o_Interrupts, 5'b00101);
        cpu_read(16'hFF0F);
        check("irq_if_rd", o_Bus, 8'hE5);
        i_Handle_Interrupt = 1'b1;
        tick();
        check("irq_clr1", o_Interrupts, 5'b00100);
        tick();  // still high: no new edge
        check("irq_no_edge", o_Interrupts, 5'b00100);
        i_Handle_Interrupt = 1'b0;
        tick();
        i_Handle_Interrupt = 1'b1;
        tick();
        i_Handle_Interrupt = 1'b0;
        check("irq_clr2", o_Interrupts, 5'b00000);

        // IF write coinciding with a source edge
        i_Irq_Lines = 5'b01000;
        cpu_write(16'hFF0F, 8'h02);
        i_Irq_Lines = 5'b00000;
        check("if_wr_or_mask", o_Interrupts, 5'b00000);
        cpu_read(16'hFF0F);
        check("if_wr_or", o_Bus, 8'hEA);

        // Set wins over clear on the same bit
        cpu_write(16'hFFFF, 8'h1F);
        check("ie_all", o_Interrupts, 5'b01010);
        i_Irq_Lines = 5'b00010; i_Handle_Interrupt = 1'b1;
        tick();
        i_Irq_Lines = 5'b00000; i_Handle_Interrupt = 1'b0;
        check("set_wins", o_Interrupts, 5'b01010);
        cpu_read(16'hFFFF);
        check("ie_rd", o_Bus, 8'h1F);

        // Disabled cycles do nothing
        i_Enable = 1'b0;
        cpu_read(16'hFF0F);
        check("disabled_rd", o_Bus, 8'h1F);
        i_Enable = 1'b1;

        // Echo region
        cpu_read(16'hE010);
`ifdef ECHO_RAM_EN
        check("echo_req", o_Ext_Req, 1'b1);
        check("echo_addr", o_Ext_Address, 16'hC010);
        i_Ext_Ack = 1'b1; i_Ext_Data = 8'h21;
        tick();
        quiet();
        check("echo_bus", o_Bus, 8'h21);
`else
        check("echo_bus", o_Bus, 8'hFF);
        check("echo_req", o_Ext_Req, 1'b0);
        check("echo_busy", o_Busy, 1'b0);
`endif

        // Reset mid-access
        cpu_read(16'h8000);
        check("mid_req", o_Ext_Req, 1'b1);
        cpu_read(16'hFF90);  // puts 0x11 nowhere: ignored while busy
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        check("mid_rst_req", o_Ext_Req, 1'b0);
        check("mid_rst_busy", o_Busy, 1'b0);
        check("mid_rst_irq", o_Interrupts, 5'd0);
        check("mid_rst_bus", o_Bus, 8'hFF);
        cpu_read(16'hFF0F);
        check("mid_rst_if", o_Bus, 8'hE0);
        cpu_read(16'hFFFF);
        check("mid_rst_ie", o_Bus, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_bus_responder.md
Name: gb_bus_responder

Overview:
- Memory-side responder for the CPU's bus-master interface.
- Latches the CPU address and serves reads/writes from internal storage: HRAM, the IF (0xFF0F) and IE (0xFFFF) interrupt registers, and the unmapped 0xFEA0-0xFEFF hole.
- Forwards all other regions to an external memory port with a req/ack handshake and a timeout.
- Generates the CPU's pending-interrupt vector and clears the serviced flag on interrupt acknowledge.

Parameters:
- TIMEOUT_CYCLES, 255, enabled cycles to wait for i_Ext_Ack before aborting an external access (1..255).
- HRAM_BASE, 16'hFF80, first HRAM address; HRAM ends at 0xFFFE (127 bytes).

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  synchronous active-high reset
- i_Enable  input  1  clock enable; all state advances only when high (reset is not gated)
- i_Address  input  16  CPU address
- i_Address_Out  input  1  CPU is presenting a new address
- i_Bus  input  8  CPU write data
- i_Bus_Out  input  1  CPU write strobe
- i_Bus_In  input  1  CPU read strobe
- i_Handle_Interrupt  input  1  CPU is servicing an interrupt
- i_Irq_Lines  input  5  raw interrupt sources (VBlank, STAT, Timer, Serial, Joypad), rising-edge sensitive
- o_Bus  output  8  read data to CPU (registered)
- o_Busy  output  1  access in progress; new strobes ignored
- o_Interrupts  output  5  IF & IE, bit0 highest priority
- o_Bus_Error  output  1  one-cycle pulse on external timeout
- o_Ext_Req  output  1  external access request
- o_Ext_We  output  1  external access is a write
- o_Ext_Address  output  16  external address
- o_Ext_Data  output  8  external write data
- i_Ext_Data  input  8  external read data
- i_Ext_Ack  input  1  external access complete

Behaviour:
- Reset values: o_Bus=0xFF; o_Busy, o_Bus_Error, o_Ext_Req, o_Ext_We=0; o_Ext_Address=0; o_Ext_Data=0; IF=0; IE=0; o_Interrupts=0; IRQ edge history=0; address latch=0; state=IDLE. HRAM contents are not reset.
- Reset mid-access drops o_Ext_Req the next cycle with no ack required.
- Address latch: enabled cycle with i_Address_Out loads i_Address. A strobe in the same cycle uses the newly latched address (bypass).
- States: IDLE, EXT_WAIT.
- IDLE, enabled, i_Bus_Out or i_Bus_In:
  - If both strobes are high, the write wins and the read is dropped.
  - Decode uses the latched address.
  - Internal hit completes with 1-cycle latency: read data appears on o_Bus the next cycle and o_Busy stays 0.
  - Internal map: HRAM_BASE..0xFFFE = HRAM; 0xFF0F = IF (reads {3'b111, IF}, writes load bits [4:0]); 0xFFFF = IE (reads {3'b000, IE}); 0xFEA0-0xFEFF reads 0xFF and ignores writes; 0xE000-0xFDFF per ECHO_RAM_EN.
  - Anything else goes external: next cycle o_Ext_Req=1, o_Busy=1, o_Ext_We=write, o_Ext_Address=latched address, o_Ext_Data=i_Bus; state moves to EXT_WAIT.
- EXT_WAIT:
  - Request outputs are held stable.
  - On i_Ext_Ack: if read, o_Bus<=i_Ext_Data; o_Ext_Req and o_Busy drop the next cycle; state returns to IDLE.
  - A wait counter increments on each enabled cycle. When it reaches TIMEOUT_CYCLES without ack: o_Bus<=0xFF on a read, o_Bus_Error pulses for 1 cycle, o_Ext_Req=0, state returns to IDLE.
  - An ack arriving on the timeout cycle counts as success.
  - CPU strobes are ignored while busy.
- o_Bus holds its value between reads; writes do not change it.
- Interrupts:
  - Each enabled cycle, a rising edge on i_Irq_Lines[n] sets IF[n].
  - o_Interrupts = IF & IE, combinational from the registers.
  - On a rising edge of i_Handle_Interrupt (enabled), the lowest set bit of IF&IE is cleared. If none is set, nothing is cleared.
  - If a source edge and the clear hit the same bit in the same cycle, set wins.
  - If a CPU write to IF and a source edge coincide, source-edge bits are ORed on top of the written value.

Optional Feature:
- Macro ECHO_RAM_EN.
- Defined: 0xE000-0xFDFF is remapped to 0xC000-0xDDFF (address minus 0x2000) and forwarded externally; o_Ext_Address shows the remapped address.
- Undefined: 0xE000-0xFDFF is internal-unmapped, reads 0xFF with 1-cycle latency and ignores writes; no external request is issued.

Test Plan:
- Address 0xFF85, write 0x5A, then read -> o_Bus=0x5A one cycle after the read strobe; o_Busy never asserted; o_Ext_Req never asserted.
- Read 0xC123, ack after 3 cycles with i_Ext_Data=0x3C -> o_Ext_Req high exactly from the cycle after the strobe until the cycle after ack; o_Ext_We=0; o_Bus=0x3C; o_Busy low afterwards.
- Read 0x8000, no ack, TIMEOUT_CYCLES=4 -> o_Bus_Error pulses once after 4 enabled wait cycles; o_Bus=0xFF; a subsequent HRAM read works.
- Write IE=0x05, pulse i_Irq_Lines=5'b00101 -> o_Interrupts=5'b00101; read 0xFF0F returns 0xE5; i_Handle_Interrupt edge -> o_Interrupts=5'b00100; second edge -> 0.
- Read 0xE010 -> with ECHO_RAM_EN, o_Ext_Address=0xC010; without it, o_Bus=0xFF and no request. Then i_Reset mid-EXT_WAIT -> next cycle o_Ext_Req=0, o_Busy=0, IF=IE=0, o_Bus=0xFF.
